// File: rtl/thermo_pkg.sv
// Shared constants and the reference thermometer-code decode for the serial pattern link.
// The table entry k is (2^(k+1))-1, so a legal word is a contiguous run of ones from bit 0.
package thermo_pkg;

    localparam int THERMO_WIDTH = 8;
    localparam int THERMO_IDX_W = 3;

    // Returns {err, index}; anything that is not a run of ones from bit 0 (including zero) is an error.
    function automatic logic [THERMO_IDX_W:0] thermo_to_index(input logic [THERMO_WIDTH-1:0] word);
        logic [THERMO_WIDTH-1:0] ones;
        logic [THERMO_IDX_W:0]   res;
        ones = '1;
        res  = {1'b1, {THERMO_IDX_W{1'b0}}};
        for (int k = 0; k < THERMO_WIDTH; k++) begin
            if (word == (ones >> (THERMO_WIDTH - 1 - k))) begin
                res = {1'b0, k[THERMO_IDX_W-1:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/thermo_decoder.sv
// Combinational thermometer-word to table-index decoder; zero latency, no flow control.
// Illegal words decode to index 0 with err set.
module thermo_decoder
    import thermo_pkg::*;
#(
    parameter int WIDTH = THERMO_WIDTH,
    parameter int IDX_W = THERMO_IDX_W
) (
    input  logic [WIDTH-1:0] word_i,
    output logic [IDX_W-1:0] index_o,
    output logic             err_o
);

    if (WIDTH == THERMO_WIDTH && IDX_W == THERMO_IDX_W) begin : g_pkg
        logic [THERMO_IDX_W:0] res;
        assign res     = thermo_to_index(word_i);
        assign index_o = res[IDX_W-1:0];
        assign err_o   = res[IDX_W];
    end else begin : g_generic
        localparam logic [WIDTH-1:0] ONES = '1;
        logic [IDX_W-1:0] idx;
        logic             err;

        always_comb begin
            idx = '0;
            err = 1'b1;
            for (int k = 0; k < WIDTH; k++) begin
                if (word_i == (ONES >> (WIDTH - 1 - k))) begin
                    idx = k[IDX_W-1:0];
                    err = 1'b0;
                end
            end
        end

        assign index_o = idx;
        assign err_o   = err;
    end

endmodule

// File: rtl/thermo_frame_receiver.sv
// LSB-first deserializer + thermometer decode; VALID/WORD/INDEX/ERR one cycle after the last bit, no backpressure
// (SIN_EN gates sampling). THERMO_RX_CHANGE_DETECT_EN adds a CHANGE pulse on a new legal index.
module thermo_frame_receiver
    import thermo_pkg::*;
#(
    parameter int WIDTH = THERMO_WIDTH,
    parameter int IDX_W = THERMO_IDX_W
) (
    input  logic             CLK,
    input  logic             CLEAR_N,
    input  logic             SIN,
    input  logic             SIN_EN,
    input  logic             FRAME_START,
    output logic [WIDTH-1:0] WORD,
    output logic [IDX_W-1:0] INDEX,
    output logic             VALID,
    output logic             ERR
`ifdef THERMO_RX_CHANGE_DETECT_EN
    ,
    output logic             CHANGE
`endif
);

    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(WIDTH - 1);

    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] asm_word;
    logic [IDX_W-1:0] dec_index;
    logic             dec_err;
    logic             frame_done;

    // The final bit bypasses the shift register so the frame decodes on the edge that samples it.
    assign asm_word   = {SIN, shift_q[WIDTH-2:0]};
    assign frame_done = SIN_EN && !FRAME_START && (cnt_q == CNT_LAST);

    thermo_decoder #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decoder (
        .word_i  (asm_word),
        .index_o (dec_index),
        .err_o   (dec_err)
    );

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        index_d = index_q;
        err_d   = err_q;
        valid_d = 1'b0;
        if (SIN_EN) begin
            if (FRAME_START) begin
                shift_d    = '0;
                shift_d[0] = SIN;
                cnt_d      = IDX_W'(1);
            end else if (frame_done) begin
                word_d  = asm_word;
                index_d = dec_index;
                err_d   = dec_err;
                valid_d = 1'b1;
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d[cnt_q] = SIN;
                cnt_d          = cnt_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLEAR_N) begin
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            index_q <= index_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign WORD  = word_q;
    assign INDEX = index_q;
    assign VALID = valid_q;
    assign ERR   = err_q;

`ifdef THERMO_RX_CHANGE_DETECT_EN
    logic [IDX_W-1:0] prev_index_q, prev_index_d;
    logic             have_prev_q, have_prev_d;
    logic             change_q, change_d;

    // Only legal frames participate; an illegal frame leaves the comparison baseline untouched.
    always_comb begin
        prev_index_d = prev_index_q;
        have_prev_d  = have_prev_q;
        change_d     = 1'b0;
        if (frame_done && !dec_err) begin
            change_d     = !have_prev_q || (dec_index != prev_index_q);
            prev_index_d = dec_index;
            have_prev_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLEAR_N) begin
            prev_index_q <= '0;
            have_prev_q  <= 1'b0;
            change_q     <= 1'b0;
        end else begin
            prev_index_q <= prev_index_d;
            have_prev_q  <= have_prev_d;
            change_q     <= change_d;
        end
    end

    assign CHANGE = change_q;
`endif

endmodule
